sa_ram_fifo_ctrl_256x3: RTL

- Flow-controlled FIFO sequencer for an external 256x3 two-port RAM: write port (wa/we/di) and read port with registered read address (ra/re, data on dout in the cycle after re).
- Converts valid/ready push and pop streams into RAM write and read commands.
- Keeps a 2-entry output skid buffer so pop runs at 1 item/cycle despite RAM read latency.
- Sits between a 3-bit producer and consumer; the RAM is instantiated one level up, beside this controller.

---
 rtl/sa_ramctl_pkg.sv | 14 +
 rtl/sa_ramctl_skid2.sv | 43 ++++
 rtl/sa_ram_fifo_ctrl_256x3.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sa_ramctl_pkg.sv
// sa_ramctl_pkg: shared constants and types for the 256x3 RAM FIFO controller.
//   DEPTH/AW/DW : default RAM geometry
//   SKID_DEPTH  : entries in the output skid buffer
//   ptr_t/cnt_t/occ_t : RAM pointer, RAM item count, total occupancy
package sa_ramctl_pkg;
    localparam int DEPTH      = 256;
    localparam int AW         = 8;
    localparam int DW         = 3;
    localparam int SKID_DEPTH = 2;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [AW+1:0] occ_t;
endpackage

// File: rtl/sa_ramctl_skid2.sv
// sa_ramctl_skid2: 2-entry output buffer that absorbs the RAM read latency.
//   clk, rst  : clock, async active-high reset
//   push_i    : capture din_i at the tail
//   din_i     : captured RAM read data
//   pop_i     : consumer took the head entry
//   dout_o    : head entry
//   cnt_o     : entries held (0..2)
module sa_ramctl_skid2
    import sa_ramctl_pkg::*;
#(
    parameter int DW = sa_ramctl_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic [1:0]    cnt_o
);
    logic [DW-1:0] mem_q [SKID_DEPTH];
    logic          head_q, tail_q;
    logic [1:0]    cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= din_i;
                tail_q        <= ~tail_q;
            end
            if (pop_i) head_q <= ~head_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign dout_o = mem_q[head_q];
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/sa_ram_fifo_ctrl_256x3.sv
// sa_ram_fifo_ctrl_256x3: valid/ready FIFO sequencer driving an external
// two-port RAM (write wa/we/di, read ra/re with dout one cycle after re).
//   clk, rst            : clock, async active-high reset
//   wr_pvld/wr_prdy/wr_pd : push stream (wr_prdy is registered)
//   rd_pvld/rd_prdy/rd_pd : pop stream, fed from a 2-entry skid buffer
//   ram_wa/we/di        : RAM write command
//   ram_ra/re/dout      : RAM read command and returned data
//   pwrbus_ram_pd       : passed through to ram_pwrbus_ram_pd
//   occ                 : items held in RAM + in flight + skid (registered)
// Optional: SA_RAMCTL_PEAK_EN adds peak_clr / occ_peak (max-occupancy tracker).
module sa_ram_fifo_ctrl_256x3
#(
    parameter int DEPTH = sa_ramctl_pkg::DEPTH,
    parameter int AW    = sa_ramctl_pkg::AW,
    parameter int DW    = sa_ramctl_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_ram_pd,
`ifdef SA_RAMCTL_PEAK_EN
    input  logic          peak_clr,
    output logic [AW+1:0] occ_peak,
`endif
    output logic [AW+1:0] occ
);
    import sa_ramctl_pkg::*;

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q, ra_q;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic [AW+1:0] occ_q, occ_d;
    logic          inflight_q, wr_prdy_q;
    logic [1:0]    out_cnt, out_cnt_d;
    logic [2:0]    pend;
    logic          push, pop, issue;

    assign push    = wr_pvld & wr_prdy_q;
    assign rd_pvld = (out_cnt != 2'd0);
    assign pop     = rd_pvld & rd_prdy;

    // Skid slots already committed after this cycle's pop; only issue a read
    // when its data is guaranteed a slot at capture time.
    assign pend  = {1'b0, out_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (ram_cnt_q != '0) && (pend < 3'(SKID_DEPTH));

    always_comb begin
        ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
        out_cnt_d = out_cnt + {1'b0, inflight_q} - {1'b0, pop};
        // occ tracks the post-edge state so it matches the registers it sums
        occ_d     = {1'b0, ram_cnt_d} + {{(AW+1){1'b0}}, issue}
                  + {{AW{1'b0}}, out_cnt_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ra_q       <= '0;
            ram_cnt_q  <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_prdy_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                ra_q     <= rd_ptr_q;
            end
            ram_cnt_q  <= ram_cnt_d;
            occ_q      <= occ_d;
            inflight_q <= issue;
            wr_prdy_q  <= (ram_cnt_d != FULL);
        end
    end

    // Capture happens the cycle after issue, when ram_dout is valid.
    sa_ramctl_skid2 #(.DW(DW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .din_i  (ram_dout),
        .pop_i  (pop),
        .dout_o (rd_pd),
        .cnt_o  (out_cnt)
    );

`ifdef SA_RAMCTL_PEAK_EN
    logic [AW+1:0] occ_peak_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     occ_peak_q <= '0;
        else if (peak_clr)           occ_peak_q <= occ_q;
        else if (occ_q > occ_peak_q) occ_peak_q <= occ_q;
    end
    assign occ_peak = occ_peak_q;
`endif

    assign wr_prdy           = wr_prdy_q;
    assign ram_we            = push;
    assign ram_wa            = wr_ptr_q;
    assign ram_di            = wr_pd;
    assign ram_re            = issue;
    assign ram_ra            = issue ? rd_ptr_q : ra_q;
    assign occ               = occ_q;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
endmodule
